// File: rtl/ddr_des_pkg.sv
// rtl/ddr_des_pkg.sv - shared types and defaults for the DDR word deserializer
// Holds the alignment FSM state type and the default word/sync parameters.
package ddr_des_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } des_state_t;

    localparam int          DEFAULT_WIDTH     = 16;
    localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hF628;
    localparam int          DEFAULT_SYNC_CNT  = 4;

endpackage

// File: rtl/ddr_des_shifter.sv
// rtl/ddr_des_shifter.sv - WIDTH+1-bit pair shift register with even/odd window mux
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_din_rise, i_din_fall sample pair (rise is the earlier bit)
//   i_din_en               pair valid; register frozen when low
//   i_slip                 selects the odd window for o_sel
//   o_even, o_odd, o_sel   windows taken from the post-shift value
module ddr_des_shifter
    import ddr_des_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_din_rise,
    input  logic             i_din_fall,
    input  logic             i_din_en,
    input  logic             i_slip,
    output logic [WIDTH-1:0] o_even,
    output logic [WIDTH-1:0] o_odd,
    output logic [WIDTH-1:0] o_sel
);

    logic [WIDTH:0] r_sr;
    logic [WIDTH:0] w_sr_next;

    // The FSM compares against the value this cycle's pair produces, so the
    // windows are taken from the next-state value rather than the register.
    assign w_sr_next = i_din_en ? {r_sr[WIDTH-2:0], i_din_rise, i_din_fall} : r_sr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sr <= '0;
        end else begin
            r_sr <= w_sr_next;
        end
    end

    assign o_even = w_sr_next[WIDTH-1:0];
    assign o_odd  = w_sr_next[WIDTH:1];
    assign o_sel  = i_slip ? o_odd : o_even;

endmodule

// File: rtl/ddr_word_deserializer.sv
// rtl/ddr_word_deserializer.sv - IDDR pair to aligned word deserializer with sync-word lock
// Build option: DDR_DES_IDLE_FILTER_EN suppresses SYNC_WORD strobes while locked.
// Ports:
//   i_clk, i_rst           sample clock, asynchronous active-high reset
//   i_din_rise, i_din_fall IDDR sample pair (rise first)
//   i_din_en               pair valid
//   i_realign              pulse: drop lock and hunt again
//   o_data                 aligned word, MSB first received
//   o_data_valid           one-cycle strobe for o_data
//   o_locked               high while locked
//   o_slip                 odd-bit alignment in use
module ddr_word_deserializer
    import ddr_des_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] SYNC_WORD = DEFAULT_SYNC_WORD,
    parameter int               SYNC_CNT  = DEFAULT_SYNC_CNT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_din_rise,
    input  logic             i_din_fall,
    input  logic             i_din_en,
    input  logic             i_realign,
    output logic [WIDTH-1:0] o_data,
    output logic             o_data_valid,
    output logic             o_locked,
    output logic             o_slip
);

    localparam int              PH_W    = $clog2(WIDTH / 2);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(WIDTH / 2 - 1);
    localparam logic [3:0]      CNT_TGT = 4'(SYNC_CNT);

    des_state_t       r_state, w_state_nxt;
    logic [PH_W-1:0]  r_phase, w_phase_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic             r_slip, w_slip_nxt;
    logic [WIDTH-1:0] r_data, w_data_nxt;
    logic             r_valid, w_valid_nxt;

    logic [WIDTH-1:0] w_even, w_odd, w_sel;
    logic             w_boundary;
    logic             w_even_hit, w_odd_hit;

    ddr_des_shifter #(.WIDTH(WIDTH)) u_shifter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_din_rise (i_din_rise),
        .i_din_fall (i_din_fall),
        .i_din_en   (i_din_en),
        .i_slip     (r_slip),
        .o_even     (w_even),
        .o_odd      (w_odd),
        .o_sel      (w_sel)
    );

    // The cycle whose pair wraps the phase counter back to 0 completes a word.
    assign w_boundary = i_din_en && (r_phase == PH_LAST);
    assign w_even_hit = (w_even == SYNC_WORD);
    assign w_odd_hit  = (w_odd == SYNC_WORD);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= HUNT;
            r_phase <= '0;
            r_cnt   <= '0;
            r_slip  <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            r_slip  <= w_slip_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        w_slip_nxt  = r_slip;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;

        if (i_din_en) begin
            w_phase_nxt = (r_phase == PH_LAST) ? '0 : r_phase + PH_W'(1);
        end

        if (i_realign) begin
            // Slip is left alone; the next hunt match decides it again.
            w_state_nxt = HUNT;
            w_cnt_nxt   = '0;
        end else if (i_din_en) begin
            case (r_state)
                HUNT: begin
                    if (w_even_hit || w_odd_hit) begin
                        w_slip_nxt  = !w_even_hit;
                        // Restart phase so this cycle counts as a boundary.
                        w_phase_nxt = '0;
                        w_cnt_nxt   = 4'd1;
                        w_state_nxt = (CNT_TGT == 4'd1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (w_boundary) begin
                        if (w_sel == SYNC_WORD) begin
                            w_cnt_nxt = r_cnt + 4'd1;
                            if (r_cnt + 4'd1 == CNT_TGT) begin
                                w_state_nxt = LOCKED;
                            end
                        end else begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = HUNT;
                        end
                    end
                end
                LOCKED: begin
                    if (w_boundary) begin
`ifdef DDR_DES_IDLE_FILTER_EN
                        if (w_sel != SYNC_WORD) begin
                            w_data_nxt  = w_sel;
                            w_valid_nxt = 1'b1;
                        end
`else
                        w_data_nxt  = w_sel;
                        w_valid_nxt = 1'b1;
`endif
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign o_data       = r_data;
    assign o_data_valid = r_valid;
    assign o_locked     = (r_state == LOCKED);
    assign o_slip       = r_slip;

endmodule

// File: tb/tb_ddr_word_deserializer.sv
// tb/tb_ddr_word_deserializer.sv - self-checking bench for ddr_word_deserializer
module tb_ddr_word_deserializer;

    localparam logic [15:0] SYNC = 16'hF628;
    localparam int          NSYNC_LOCK = 4;
`ifdef DDR_DES_IDLE_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_din_rise = 1'b0;
    logic        i_din_fall = 1'b0;
    logic        i_din_en = 1'b0;
    logic        i_realign = 1'b0;
    logic [15:0] o_data;
    logic        o_data_valid;
    logic        o_locked;
    logic        o_slip;

    always #5 clk = ~clk;

    ddr_word_deserializer #(
        .WIDTH     (16),
        .SYNC_WORD (16'hF628),
        .SYNC_CNT  (4)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_din_rise   (i_din_rise),
        .i_din_fall   (i_din_fall),
        .i_din_en     (i_din_en),
        .i_realign    (i_realign),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_locked     (o_locked),
        .o_slip       (o_slip)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_last = '0;
    bit          bq[$];

    typedef struct {
        string       name;
        int          junk;
        int          nsync;
        logic [15:0] p0;
        logic [15:0] p1;
        int          npay;
        logic        exp_lock;
        logic        exp_slip;
    } row_t;

    row_t rows[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard pop on every strobe.
    always @(negedge clk) begin
        if (!i_rst && o_data_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_strobe: got %h expected none", o_data);
            end else begin
                check("strobe_data", {16'h0, o_data}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic drive(input bit r, input bit f, input bit en, input bit rl);
        @(posedge clk);
        #1;
        i_din_rise = r;
        i_din_fall = f;
        i_din_en   = en;
        i_realign  = rl;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_word(input logic [15:0] w);
        if (!(FILT && w == SYNC)) begin
            exp_q.push_back(w);
            exp_last = w;
        end
    endtask

    task automatic put_word(input logic [15:0] w, input bit strobe);
        for (int i = 15; i >= 0; i--) bq.push_back(w[i]);
        if (strobe) expect_word(w);
    endtask

    task automatic flush_n(input int n);
        for (int i = 0; i < n && bq.size() >= 2; i++) begin
            bit b1, b2;
            b1 = bq.pop_front();
            b2 = bq.pop_front();
            drive(b1, b2, 1'b1, 1'b0);
        end
    endtask

    task automatic flush();
        flush_n(1000);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        i_rst = 1'b1;
        i_din_en = 1'b0;
        i_realign = 1'b0;
        exp_q.delete();
        bq.delete();
        exp_last = '0;
        @(negedge clk);
        check("rst_data", {16'h0, o_data}, 32'h0);
        check("rst_valid", {31'h0, o_data_valid}, 32'h0);
        check("rst_locked", {31'h0, o_locked}, 32'h0);
        check("rst_slip", {31'h0, o_slip}, 32'h0);
        @(posedge clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic lock_even();
        for (int s = 0; s < 5; s++) put_word(SYNC, s >= NSYNC_LOCK);
        flush();
    endtask

    task automatic end_row(input string name);
        idle(3);
        check({name, "_queue_empty"}, exp_q.size(), 32'h0);
    endtask

    initial begin
        rows[0] = '{"even_lock",   0, 5, 16'h1234, 16'hABCD, 2, 1'b1, 1'b0};
        rows[1] = '{"odd_lock",    1, 5, 16'h5555, 16'h0000, 1, 1'b1, 1'b1};
        rows[2] = '{"verify_fail", 0, 2, 16'h0000, 16'h0000, 1, 1'b0, 1'b0};
        rows[3] = '{"exact_cnt",   0, 4, 16'hC3C3, 16'h0000, 1, 1'b1, 1'b0};
        rows[4] = '{"short_cnt",   0, 3, 16'h1234, 16'h0000, 1, 1'b0, 1'b0};
        rows[5] = '{"idle_mix",    0, 6, 16'h00FF, 16'h0000, 1, 1'b1, 1'b0};

        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int j = 0; j < rows[r].junk; j++) bq.push_back(1'b0);
            for (int s = 0; s < rows[r].nsync; s++)
                put_word(SYNC, rows[r].nsync >= NSYNC_LOCK && s >= NSYNC_LOCK);
            for (int p = 0; p < rows[r].npay; p++)
                put_word((p == 0) ? rows[r].p0 : rows[r].p1, rows[r].nsync >= NSYNC_LOCK);
            if (bq.size() % 2 != 0) bq.push_back(1'b0);
            flush();
            end_row(rows[r].name);
            check({rows[r].name, "_locked"}, {31'h0, o_locked}, {31'h0, rows[r].exp_lock});
            check({rows[r].name, "_slip"}, {31'h0, o_slip}, {31'h0, rows[r].exp_slip});
            check({rows[r].name, "_data"}, {16'h0, o_data}, {16'h0, exp_last});
        end

        // REALIGN mid-word while locked, then relock on fresh syncs.
        do_reset();
        lock_even();
        put_word(16'h1234, 1'b0);
        flush_n(3);
        begin
            bit b1, b2;
            b1 = bq.pop_front();
            b2 = bq.pop_front();
            drive(b1, b2, 1'b1, 1'b1);
        end
        flush_n(1);
        @(negedge clk);
        check("realign_locked", {31'h0, o_locked}, 32'h0);
        check("realign_data_hold", {16'h0, o_data}, {16'h0, exp_last});
        flush();
        for (int s = 0; s < 3; s++) put_word(SYNC, 1'b0);
        flush();
        idle(2);
        check("relock_3_sync", {31'h0, o_locked}, 32'h0);
        put_word(SYNC, 1'b0);
        flush();
        idle(2);
        check("relock_4_sync", {31'h0, o_locked}, 32'h1);
        put_word(16'h9999, 1'b1);
        flush();
        end_row("realign");

        // DIN_EN gaps inside a locked word.
        do_reset();
        lock_even();
        put_word(16'h1234, 1'b1);
        while (bq.size() >= 2) begin
            bit b1, b2;
            b1 = bq.pop_front();
            b2 = bq.pop_front();
            drive(b1, b2, 1'b1, 1'b0);
            drive(1'($urandom), 1'($urandom), 1'b0, 1'b0);
        end
        end_row("en_gaps");
        check("en_gaps_data", {16'h0, o_data}, 32'h1234);

        // Asynchronous reset between edges while locked, mid-word.
        do_reset();
        lock_even();
        put_word(16'h1234, 1'b0);
        flush_n(3);
        @(posedge clk);
        #3;
        i_rst = 1'b1;
        #1;
        check("async_rst_locked", {31'h0, o_locked}, 32'h0);
        check("async_rst_valid", {31'h0, o_data_valid}, 32'h0);
        check("async_rst_data", {16'h0, o_data}, 32'h0);
        check("async_rst_slip", {31'h0, o_slip}, 32'h0);
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        bq.delete();
        put_word(16'h1234, 1'b0);
        flush();
        end_row("async_rst");
        check("async_rst_relock", {31'h0, o_locked}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
